// File: rtl/branch_resolve.sv
// EX-stage branch resolution: computes the real next PC and compares it with the
// fetch prediction. On a mispredict it issues a one-shot redirect and flushes the front end.
//   state    | meaning
//   IDLE     | evaluating EX control transfers
//   REDIRECT | redirect_pc presented to fetch, held while stalled
//   DRAIN    | one extra flush cycle for the wrong-path instruction now in EX
module branch_resolve (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [6:0]  ex_opcode,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic [31:0] ex_pred_pc,
  input  logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam logic [6:0] OP_B_TYPE = 7'b1100011;
  localparam logic [6:0] OP_J_JAL  = 7'b1101111;
  localparam logic [6:0] OP_I_JALR = 7'b1100111;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REDIRECT = 2'd1;
  localparam logic [1:0] DRAIN    = 2'd2;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [1:0]  state_q, state_d;
  logic [31:0] rpc_q, rpc_d;
  logic [31:0] br_q, br_d;
  logic [31:0] mis_q, mis_d;

  logic        is_branch, is_jal, is_jalr, is_ctrl;
  logic        br_taken;
  logic [31:0] pc_rel_tgt, jalr_tgt, seq_pc, actual_pc;
  logic        accept, mispredict;

  assign is_branch = (ex_opcode == OP_B_TYPE);
  assign is_jal    = (ex_opcode == OP_J_JAL);
  assign is_jalr   = (ex_opcode == OP_I_JALR);
  assign is_ctrl   = is_branch | is_jal | is_jalr;

  always_comb begin
    br_taken = 1'b0;
    unique case (ex_funct3)
      3'b000:  br_taken = (ex_rs1 == ex_rs2);
      3'b001:  br_taken = (ex_rs1 != ex_rs2);
      3'b100:  br_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  br_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  br_taken = (ex_rs1 <  ex_rs2);
      3'b111:  br_taken = (ex_rs1 >= ex_rs2);
      default: br_taken = 1'b0;
    endcase
  end

  // All adders wrap modulo 2^32 by construction of the 32-bit result width.
  assign pc_rel_tgt = ex_pc + ex_imm;
  assign jalr_tgt   = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
  assign seq_pc     = ex_pc + 32'd4;

  always_comb begin
    actual_pc = seq_pc;
    if (is_jalr) begin
      actual_pc = jalr_tgt;
    end else if (is_jal || (is_branch && br_taken)) begin
      actual_pc = pc_rel_tgt;
    end
  end

  assign accept     = (state_q == IDLE) && ex_valid && !stall && is_ctrl;
  assign mispredict = accept && (actual_pc != ex_pred_pc);

  always_comb begin
    state_d = state_q;
    rpc_d   = rpc_q;
    unique case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d = REDIRECT;
          rpc_d   = actual_pc;
        end
      end
      REDIRECT: begin
        if (!stall) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    br_d  = br_q;
    mis_d = mis_q;
    if (accept && (br_q != CNT_MAX)) begin
      br_d = br_q + 32'd1;
    end
    if (mispredict && (mis_q != CNT_MAX)) begin
      mis_d = mis_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rpc_q   <= 32'd0;
      br_q    <= 32'd0;
      mis_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      rpc_q   <= rpc_d;
      br_q    <= br_d;
      mis_q   <= mis_d;
    end
  end

  assign redirect_valid = (state_q == REDIRECT);
  assign flush          = (state_q == REDIRECT) || (state_q == DRAIN);
  assign redirect_pc    = rpc_q;
  assign br_count       = br_q;
  assign mispred_count  = mis_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: an abstract model checked every cycle plus
// literal expectations at the key points of each scenario.
module tb_branch_resolve;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2, ex_pred_pc;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] br_count, mispred_count;

  int checks = 0;
  int errors = 0;

  branch_resolve dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_pred_pc(ex_pred_pc), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] B   = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JR  = 7'b1100111;
  localparam logic [6:0] ALU = 7'b0010011;

  // Model: next-PC by plain arithmetic; redirect tracked as "cycles of flush left".
  int          m_phase;  // 0 none, 1 redirect pending, 2 last flush cycle
  logic [31:0] m_rpc;
  longint      m_br, m_mis;

  function automatic logic [31:0] model_next(input logic [6:0] op, input logic [2:0] f3,
      input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    bit taken;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a); ub = longint'(b);
    taken = 0;
    if (f3 == 3'd0) taken = (ua == ub);
    if (f3 == 3'd1) taken = (ua != ub);
    if (f3 == 3'd4) taken = (sa < sb);
    if (f3 == 3'd5) taken = (sa >= sb);
    if (f3 == 3'd6) taken = (ua < ub);
    if (f3 == 3'd7) taken = (ua >= ub);
    if (op == JR)
      return 32'((((ua + longint'(imm)) % 64'h1_0000_0000) / 2) * 2);
    if (op == JAL || (op == B && taken))
      return 32'((longint'(pc) + longint'(imm)) % 64'h1_0000_0000);
    return 32'((longint'(pc) + 4) % 64'h1_0000_0000);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_rpc = 0; m_br = 0; m_mis = 0;
    end else if (m_phase == 1) begin
      if (!stall) m_phase = 2;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else if (ex_valid && !stall && (ex_opcode == B || ex_opcode == JAL || ex_opcode == JR)) begin
      logic [31:0] nxt;
      nxt = model_next(ex_opcode, ex_funct3, ex_pc, ex_imm, ex_rs1, ex_rs2);
      if (m_br < 64'hFFFF_FFFF) m_br = m_br + 1;
      if (nxt != ex_pred_pc) begin
        if (m_mis < 64'hFFFF_FFFF) m_mis = m_mis + 1;
        m_rpc = nxt;
        m_phase = 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("m_redirect_valid", {31'd0, redirect_valid}, {31'd0, m_phase == 1});
    check("m_flush", {31'd0, flush}, {31'd0, m_phase != 0});
    check("m_redirect_pc", redirect_pc, m_rpc);
    check("m_br_count", br_count, 32'(m_br));
    check("m_mispred_count", mispred_count, 32'(m_mis));
  end

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
      input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] pred);
    ex_valid = v; ex_opcode = op; ex_funct3 = f3; ex_pc = pc; ex_imm = imm;
    ex_rs1 = a; ex_rs2 = b; ex_pred_pc = pred;
  endtask

  task automatic idle();
    drive(1'b0, ALU, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0;
    idle();
    tick(); tick();
    check("reset_rv", {31'd0, redirect_valid}, 32'd0);
    check("reset_br", br_count, 32'd0);
    rst_n = 1'b1;
    tick();

    // Correct BEQ backwards branch
    drive(1, B, 3'b000, 32'h100, 32'hFFFF_FFF0, 32'd5, 32'd5, 32'hF0);
    tick(); idle();
    check("beq_br", br_count, 32'd1);
    check("beq_mis", mispred_count, 32'd0);
    check("beq_rv", {31'd0, redirect_valid}, 32'd0);

    // BNE equal operands predicted taken -> redirect to fall-through
    drive(1, B, 3'b001, 32'h200, 32'h20, 32'd7, 32'd7, 32'h220);
    tick(); idle();
    check("bne_rv", {31'd0, redirect_valid}, 32'd1);
    check("bne_rpc", redirect_pc, 32'h204);
    check("bne_mis", mispred_count, 32'd1);
    check("bne_flush1", {31'd0, flush}, 32'd1);
    tick();
    check("bne_flush2", {31'd0, flush}, 32'd1);
    check("bne_drain_rv", {31'd0, redirect_valid}, 32'd0);
    tick();
    check("bne_flush_end", {31'd0, flush}, 32'd0);

    // JALR clears bit 0; BEQ arriving during DRAIN must be ignored
    drive(1, JR, 3'b000, 32'h0, 32'h4, 32'h1003, 32'd0, 32'h0);
    tick(); idle();
    check("jalr_rpc", redirect_pc, 32'h1006);
    tick();
    drive(1, B, 3'b000, 32'h40, 32'h8, 32'd1, 32'd1, 32'h0);
    tick(); idle();
    check("drain_ignore_br", br_count, 32'd3);
    check("drain_ignore_mis", mispred_count, 32'd2);

    // JAL mispredict with 3 stalled cycles in REDIRECT
    drive(1, JAL, 3'b000, 32'h300, 32'h40, 32'd0, 32'd0, 32'h304);
    tick(); idle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall_rv", {31'd0, redirect_valid}, 32'd1);
      tick();
    end
    check("stall_rv_4th", {31'd0, redirect_valid}, 32'd1);
    check("stall_rpc", redirect_pc, 32'h340);
    stall = 1'b0;
    tick();
    check("stall_drain_rv", {31'd0, redirect_valid}, 32'd0);
    check("stall_drain_flush", {31'd0, flush}, 32'd1);
    tick();
    check("stall_idle_flush", {31'd0, flush}, 32'd0);

    // BLTU vs BLT on 0xFFFFFFFF / 1, both predicted correctly
    drive(1, B, 3'b110, 32'h400, 32'h80, 32'hFFFF_FFFF, 32'd1, 32'h404);
    tick();
    drive(1, B, 3'b100, 32'h400, 32'h80, 32'hFFFF_FFFF, 32'd1, 32'h480);
    tick(); idle();
    check("blt_br", br_count, 32'd6);
    check("blt_mis", mispred_count, 32'd4 - 32'd1);

    // Not-taken at top of address space wraps to 0
    drive(1, B, 3'b000, 32'hFFFF_FFFC, 32'h10, 32'd1, 32'd2, 32'h8);
    tick(); idle();
    check("wrap_rpc", redirect_pc, 32'h0);
    check("wrap_rv", {31'd0, redirect_valid}, 32'd1);
    tick(); tick();
    // redirect_pc holds its last value outside REDIRECT
    check("hold_rpc", redirect_pc, 32'h0);

    // Reserved funct3 010 is never taken
    drive(1, B, 3'b010, 32'h500, 32'h10, 32'd3, 32'd3, 32'h510);
    tick(); idle();
    check("f3_010_rpc", redirect_pc, 32'h504);
    tick(); tick();

    // Non-control opcode and stalled branch are not counted
    drive(1, ALU, 3'b000, 32'h600, 32'h10, 32'd0, 32'd0, 32'h0);
    tick();
    drive(1, B, 3'b000, 32'h600, 32'h10, 32'd0, 32'd0, 32'h0);
    stall = 1'b1;
    tick(); idle(); stall = 1'b0;
    check("noncount_br", br_count, 32'd8);
    check("noncount_rv", {31'd0, redirect_valid}, 32'd0);

    // Async reset in the middle of REDIRECT
    drive(1, JAL, 3'b000, 32'h600, 32'h8, 32'd0, 32'd0, 32'h0);
    tick(); idle();
    check("pre_rst_rv", {31'd0, redirect_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rv", {31'd0, redirect_valid}, 32'd0);
    check("arst_flush", {31'd0, flush}, 32'd0);
    check("arst_rpc", redirect_pc, 32'd0);
    check("arst_br", br_count, 32'd0);
    check("arst_mis", mispred_count, 32'd0);
    #2 rst_n = 1'b1;
    drive(1, B, 3'b000, 32'h100, 32'hFFFF_FFF0, 32'd5, 32'd5, 32'hF0);
    tick(); idle();
    check("resume_br", br_count, 32'd1);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ex_valid, input, 1, EX stage holds a real instruction this cycle.
REQ-004 SHALL have port ex_opcode, input, 7, instruction[6:0] of the EX instruction.
REQ-005 SHALL have port ex_funct3, input, 3, instruction[14:12] of the EX instruction.
REQ-006 SHALL have port ex_pc, input, 32, PC of the EX instruction.
REQ-007 SHALL have port ex_imm, input, 32, sign-extended SB, UJ or I immediate for the EX instruction.
REQ-008 SHALL have port ex_rs1, input, 32, forwarded rs1 value.
REQ-009 SHALL have port ex_rs2, input, 32, forwarded rs2 value.
REQ-010 SHALL have port ex_pred_pc, input, 32, next-PC chosen by the fetch-stage predictor and carried down the pipe with the instruction.
REQ-011 SHALL have port stall, input, 1, pipeline hold; EX contents are not advancing.
REQ-012 SHALL have port redirect_valid, output, 1, fetch must load redirect_pc.
REQ-013 SHALL have port redirect_pc, output, 32, corrected next PC.
REQ-014 SHALL have port flush, output, 1, invalidate the IF/ID and ID/EX registers.
REQ-015 SHALL have port br_count, output, 32, resolved control-transfer count.
REQ-016 SHALL have port mispred_count, output, 32, misprediction count.

Function
REQ-017 SHALL classify the EX instruction as control transfer only when ex_opcode equals the codebase B_TYPE, J_JAL or I_JALR opcode define.
REQ-018 SHALL evaluate B_TYPE taken from ex_funct3 as follows: 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU.
REQ-019 SHALL treat B_TYPE with funct3 010 or 011 as not taken.
REQ-020 SHALL compute the actual next PC as ex_pc+ex_imm for a taken branch or JAL, (ex_rs1+ex_imm) with bit0 cleared for JALR, and ex_pc+4 otherwise.
REQ-021 SHALL compute all PC arithmetic modulo 2^32, with wrap-around and no overflow detection.
REQ-022 SHALL accept (evaluate) an instruction only when the FSM is IDLE, ex_valid=1, stall=0 and the opcode is a control transfer.
REQ-023 SHALL declare a mispredict on an accepted instruction when the actual next PC differs from ex_pred_pc.
REQ-024 SHALL implement FSM states IDLE, REDIRECT and DRAIN.
REQ-025 SHALL go IDLE->REDIRECT on the clock edge that accepts a mispredict, registering the actual next PC into redirect_pc.
REQ-026 SHALL, in REDIRECT, drive redirect_valid=1 and flush=1, and remain in REDIRECT while stall=1.
REQ-027 SHALL go REDIRECT->DRAIN on the first edge with stall=0, so that redirect_valid is high for at least 1 cycle and is consumed exactly once.
REQ-028 SHALL, in DRAIN, drive flush=1 and redirect_valid=0, and go DRAIN->IDLE unconditionally on the next edge.
REQ-029 SHALL ignore ex_valid in REDIRECT and DRAIN (wrong-path), with no counting and no evaluation.
REQ-030 SHALL hold redirect_pc stable outside REDIRECT at its last loaded value.
REQ-031 SHALL increment br_count by 1 on each accepted instruction, and mispred_count by 1 on each accepted mispredict, on the same edge.
REQ-032 SHALL saturate both counters at 32'hFFFFFFFF with no wrap.
REQ-033 SHALL produce no redirect and no count on a correct prediction, or on a non-control-transfer instruction.
REQ-034 SHALL give a resolution-to-redirect latency of exactly 1 clock (registered outputs only, no combinational input-to-output path).

Reset
REQ-035 SHALL, on rst_n low at any time including mid-REDIRECT or mid-DRAIN, immediately force the FSM to IDLE, redirect_valid=0, flush=0, redirect_pc=0, br_count=0 and mispred_count=0.
REQ-036 SHALL resume evaluation on the first rising clk edge after rst_n deasserts.

Verification
REQ-037 Bench SHALL cover: BEQ at ex_pc=0x100, imm=0xFFFFFFF0, rs1=rs2=5, pred=0xF0 -> no redirect; br_count=1, mispred_count=0.
REQ-038 Bench SHALL cover: BNE at ex_pc=0x200, imm=0x20, rs1=rs2, pred=0x220 -> next cycle redirect_valid=1, redirect_pc=0x204, flush high for 2 cycles, mispred_count=1.
REQ-039 Bench SHALL cover: JALR with rs1=0x1003, imm=0x4, pred=0x0 -> redirect_pc=0x1006; a valid BEQ presented during DRAIN is not counted.
REQ-040 Bench SHALL cover: mispredict with stall=1 held for 3 cycles in REDIRECT -> redirect_valid high for 4 cycles, then DRAIN for 1 cycle, then IDLE.
REQ-041 Bench SHALL cover: BLTU rs1=0xFFFFFFFF, rs2=1 versus BLT with the same operands -> BLTU not taken, BLT taken; ex_pc=0xFFFFFFFC with not-taken gives next PC 0x0.
REQ-042 Bench SHALL cover: rst_n pulsed low during REDIRECT -> all outputs 0 asynchronously, before the next clk edge.
